// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types and helpers for the load/store unit
// Purpose: FSM state enum, access size enum, RISC-V load/store funct3 encodings,
//   funct3 legality and natural-alignment helpers used by load_store_unit.
// Ports: none (package).
// Config: LSU_MISALIGN_SPLIT_EN adds the ST_REQ_HI state for word-crossing accesses.
package lsu_pkg;

  typedef enum logic [2:0] {
    LF3_LB  = 3'b000,
    LF3_LH  = 3'b001,
    LF3_LW  = 3'b010,
    LF3_LD  = 3'b011,
    LF3_LBU = 3'b100,
    LF3_LHU = 3'b101,
    LF3_LWU = 3'b110
  } load_funct3_t;

  typedef enum logic [2:0] {
    SF3_SB = 3'b000,
    SF3_SH = 3'b001,
    SF3_SW = 3'b010,
    SF3_SD = 3'b011
  } store_funct3_t;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } lsu_size_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ_LO = 2'd1,
    ST_DONE   = 2'd2
`ifdef LSU_MISALIGN_SPLIT_EN
    , ST_REQ_HI = 2'd3
`endif
  } lsu_state_t;

  // Stores only have the sb/sh/sw/sd encodings; doubleword and lwu need XLEN=64.
  function automatic logic lsu_funct3_legal(input logic is_store, input logic [2:0] funct3,
                                            input logic xlen64);
    logic ok;
    if (is_store) begin
      ok = !funct3[2] && (xlen64 || (funct3[1:0] != SZ_D));
    end else begin
      case (funct3)
        LF3_LD, LF3_LWU: ok = xlen64;
        3'b111:          ok = 1'b0;
        default:         ok = 1'b1;
      endcase
    end
    return ok;
  endfunction

  // True when the byte offset is not a multiple of the access size.
  function automatic logic lsu_misaligned(input logic [1:0] sz, input logic [2:0] off);
    logic [2:0] mask;
    case (lsu_size_t'(sz))
      SZ_B:    mask = 3'b000;
      SZ_H:    mask = 3'b001;
      SZ_W:    mask = 3'b011;
      default: mask = 3'b111;
    endcase
    return |(off & mask);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - combinational byte-lane, store-shift and load-extend datapath
// Purpose: from funct3 and the byte offset, builds memory byte enables and the
//   lane-shifted store word, and selects/merges/extends returned load data.
// Ports: funct3, off (addr mod NB), wdata (LSB-justified store data), rdata_lo
//   (first/only read word); byte_en_lo, wdata_lo, ld_data. With
//   LSU_MISALIGN_SPLIT_EN also rdata_hi, byte_en_hi, wdata_hi, crosses.
import lsu_pkg::*;

module lsu_align #(
  parameter int XLEN = 32
) (
  input  logic [2:0]                  funct3,
  input  logic [$clog2(XLEN/8)-1:0]   off,
  input  logic [XLEN-1:0]             wdata,
  input  logic [XLEN-1:0]             rdata_lo,
`ifdef LSU_MISALIGN_SPLIT_EN
  input  logic [XLEN-1:0]             rdata_hi,
  output logic [XLEN/8-1:0]           byte_en_hi,
  output logic [XLEN-1:0]             wdata_hi,
  output logic                        crosses,
`endif
  output logic [XLEN/8-1:0]           byte_en_lo,
  output logic [XLEN-1:0]             wdata_lo,
  output logic [XLEN-1:0]             ld_data
);

  localparam int NB = XLEN / 8;

  lsu_size_t       sz;
  logic [3:0]      size_b;
  logic [XLEN-1:0] size_mask;
  logic [XLEN-1:0] sign_pos;
  logic [XLEN-1:0] sel;
  logic            sign_bit;
`ifdef LSU_MISALIGN_SPLIT_EN
  logic [2*NB-1:0]   en_full;
  logic [2*XLEN-1:0] wd_full;
  logic [2*XLEN-1:0] merged;
`else
  logic [NB-1:0]     en_w;
`endif

  always_comb begin
    sz        = lsu_size_t'(funct3[1:0]);
    size_b    = 4'd1 << sz;
    size_mask = (int'(size_b) >= NB) ? '1 : ((XLEN'(1) << (8 * size_b)) - XLEN'(1));
`ifdef LSU_MISALIGN_SPLIT_EN
    // Treat two consecutive words as one 2*NB-byte window; the upper half is the
    // second (addr+NB) access when the access crosses the word boundary.
    en_full    = ((2 * NB)'(1) << size_b) - (2 * NB)'(1);
    en_full    = en_full << off;
    wd_full    = {{XLEN{1'b0}}, wdata & size_mask} << (8 * off);
    byte_en_lo = en_full[NB-1:0];
    byte_en_hi = en_full[2*NB-1:NB];
    wdata_lo   = wd_full[XLEN-1:0];
    wdata_hi   = wd_full[2*XLEN-1:XLEN];
    crosses    = |en_full[2*NB-1:NB];
    merged     = {rdata_hi, rdata_lo} >> (8 * off);
    sel        = merged[XLEN-1:0];
`else
    en_w       = (NB'(1) << size_b) - NB'(1);
    byte_en_lo = en_w << off;
    wdata_lo   = (wdata & size_mask) << (8 * off);
    sel        = rdata_lo >> (8 * off);
`endif
    // Top bit of the size mask marks the sign bit of the loaded quantity.
    sign_pos = size_mask ^ (size_mask >> 1);
    sign_bit = |(sel & sign_pos);
    ld_data  = (sel & size_mask) | ((!funct3[2] && sign_bit) ? ~size_mask : '0);
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - MEM-stage load/store unit for variable-latency memory
// Purpose: accepts one load/store per valid/ready handshake, issues an NB-aligned
//   memory request held until mem_resp, returns extended load data with a
//   one-cycle resp_valid pulse. Illegal funct3 or unsupported misalignment
//   completes with resp_err and no memory access.
// Ports: clk, rst (async, active-low); req_valid/req_ready/req_is_store/
//   req_funct3/req_addr/req_wdata; resp_valid/resp_rdata/resp_err;
//   mem_addr/mem_read/mem_write/mem_byte_en/mem_wdata/mem_rdata/mem_resp.
// Config: LSU_MISALIGN_SPLIT_EN - word-crossing accesses become two requests
//   (REQ_LO then REQ_HI); otherwise any misaligned access is an error.
import lsu_pkg::*;

module load_store_unit #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_store,
  input  logic [2:0]        req_funct3,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_err,
  output logic [XLEN-1:0]   mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [XLEN/8-1:0] mem_byte_en,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic              mem_resp
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);

  lsu_state_t      state_q, state_d;
  logic            is_store_q, is_store_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] resp_rdata_q, resp_rdata_d;
  logic            resp_err_q, resp_err_d;

  logic            accept;
  logic            req_err;
  logic            mem_done;
  logic [XLEN-1:0] word_addr;
  logic [NB-1:0]   en_lo;
  logic [XLEN-1:0] wdata_lo;
  logic [XLEN-1:0] ld_data;
`ifdef LSU_MISALIGN_SPLIT_EN
  logic [XLEN-1:0] lo_q, lo_d;
  logic [NB-1:0]   en_hi;
  logic [XLEN-1:0] wdata_hi;
  logic            crosses;
`endif

  assign word_addr = addr_q & ~XLEN'(NB - 1);

  lsu_align #(.XLEN(XLEN)) u_align (
    .funct3     (funct3_q),
    .off        (addr_q[OFFW-1:0]),
    .wdata      (wdata_q),
`ifdef LSU_MISALIGN_SPLIT_EN
    // In REQ_HI the first word was captured in lo_q; the live word is the upper one.
    .rdata_lo   ((state_q == ST_REQ_HI) ? lo_q : mem_rdata),
    .rdata_hi   (mem_rdata),
    .byte_en_hi (en_hi),
    .wdata_hi   (wdata_hi),
    .crosses    (crosses),
`else
    .rdata_lo   (mem_rdata),
`endif
    .byte_en_lo (en_lo),
    .wdata_lo   (wdata_lo),
    .ld_data    (ld_data)
  );

  // Held low through reset so the pipeline never hands over a request mid-reset.
  assign req_ready = rst && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign accept    = req_valid && req_ready;

  always_comb begin
    req_err = !lsu_funct3_legal(req_is_store, req_funct3, XLEN == 64);
`ifndef LSU_MISALIGN_SPLIT_EN
    req_err = req_err || lsu_misaligned(req_funct3[1:0], 3'(req_addr[OFFW-1:0]));
`endif
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) state_d = req_err ? ST_DONE : ST_REQ_LO;
        else        state_d = ST_IDLE;
      end
      ST_REQ_LO: begin
        if (mem_resp) begin
`ifdef LSU_MISALIGN_SPLIT_EN
          state_d = crosses ? ST_REQ_HI : ST_DONE;
`else
          state_d = ST_DONE;
`endif
        end
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      ST_REQ_HI: if (mem_resp) state_d = ST_DONE;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Request latch and response capture
  always_comb begin
    is_store_d   = is_store_q;
    funct3_d     = funct3_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
`ifdef LSU_MISALIGN_SPLIT_EN
    lo_d         = lo_q;
    if ((state_q == ST_REQ_LO) && mem_resp) lo_d = mem_rdata;
`endif
    mem_done = mem_resp && (state_d == ST_DONE) &&
               ((state_q == ST_REQ_LO)
`ifdef LSU_MISALIGN_SPLIT_EN
                || (state_q == ST_REQ_HI)
`endif
               );
    if (accept) begin
      is_store_d = req_is_store;
      funct3_d   = req_funct3;
      addr_d     = req_addr;
      wdata_d    = req_wdata;
      if (req_err) begin
        resp_err_d   = 1'b1;
        resp_rdata_d = '0;
      end
    end
    if (mem_done) begin
      resp_err_d   = 1'b0;
      resp_rdata_d = is_store_q ? '0 : ld_data;
    end
  end

  // Outputs
  always_comb begin
    mem_addr    = '0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_byte_en = '0;
    mem_wdata   = '0;
    resp_valid  = (state_q == ST_DONE);
    resp_rdata  = resp_rdata_q;
    resp_err    = resp_err_q;
    unique case (state_q)
      ST_REQ_LO: begin
        mem_read    = !is_store_q;
        mem_write   = is_store_q;
        mem_addr    = word_addr;
        mem_byte_en = en_lo;
        mem_wdata   = is_store_q ? wdata_lo : '0;
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      ST_REQ_HI: begin
        mem_read    = !is_store_q;
        mem_write   = is_store_q;
        mem_addr    = word_addr + XLEN'(NB);
        mem_byte_en = en_hi;
        mem_wdata   = is_store_q ? wdata_hi : '0;
      end
`endif
      default: ;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      is_store_q   <= 1'b0;
      funct3_q     <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
      lo_q         <= '0;
`endif
    end else begin
      state_q      <= state_d;
      is_store_q   <= is_store_d;
      funct3_q     <= funct3_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
`ifdef LSU_MISALIGN_SPLIT_EN
      lo_q         <= lo_d;
`endif
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit (XLEN=32)
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_is_store = 1'b0;
  logic [2:0]  req_funct3 = 3'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic        mem_read;
  logic        mem_write;
  logic [3:0]  mem_byte_en;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_resp = 1'b0;

  int n_vec = 0;
  int n_bad = 0;

  load_store_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte_en(mem_byte_en), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge with the unit idle; returns at a negedge with it idle again.
  task automatic do_op(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input int lat, input logic [31:0] rd,
                       input logic [31:0] e_addr, input logic [3:0] e_en,
                       input logic [31:0] e_wdata, input logic [31:0] e_rdata,
                       input logic e_err);
    req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    chk("req_ready", 64'(req_ready), 64'(1));
    @(negedge clk);
    req_valid = 1'b0;
    if (e_err) begin
      chk("err resp_valid", 64'(resp_valid), 64'(1));
      chk("err resp_err", 64'(resp_err), 64'(1));
      chk("err no mem access", 64'(mem_read | mem_write), 64'(0));
    end else begin
      chk("mem_read", 64'(mem_read), 64'(!st));
      chk("mem_write", 64'(mem_write), 64'(st));
      chk("mem_addr", 64'(mem_addr), 64'(e_addr));
      chk("mem_byte_en", 64'(mem_byte_en), 64'(e_en));
      if (st) chk("mem_wdata", 64'(mem_wdata), 64'(e_wdata));
      for (int i = 0; i < lat; i++) begin
        @(negedge clk);
        chk("held req/en/no resp", {59'd0, mem_read | mem_write, resp_valid, mem_byte_en[2:0]},
            {59'd0, 1'b1, 1'b0, e_en[2:0]});
      end
      mem_resp = 1'b1; mem_rdata = rd;
      @(negedge clk);
      mem_resp = 1'b0; mem_rdata = '0;
      chk("resp_valid", 64'(resp_valid), 64'(1));
      chk("resp_err", 64'(resp_err), 64'(0));
      chk("resp_rdata", 64'(resp_rdata), 64'(e_rdata));
      chk("mem idle at resp", 64'(mem_read | mem_write), 64'(0));
    end
    @(negedge clk);
    chk("resp pulse ends", 64'(resp_valid), 64'(0));
    chk("resp_rdata held", 64'(resp_rdata), 64'(e_rdata));
  endtask

  initial begin
    @(negedge clk);
    chk("rst req_ready", 64'(req_ready), 64'(0));
    chk("rst outputs", {resp_valid, resp_err, mem_read, mem_write, mem_byte_en, resp_rdata, mem_addr[27:0]}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // lw aligned, 3-cycle memory latency
    do_op(1'b0, 3'b010, 32'h1000_0004, 32'h0, 3, 32'hDEAD_BEEF,
          32'h1000_0004, 4'b1111, 32'h0, 32'hDEAD_BEEF, 1'b0);
    // lb / lbu top byte
    do_op(1'b0, 3'b000, 32'h1000_0003, 32'h0, 1, 32'h8000_0000,
          32'h1000_0000, 4'b1000, 32'h0, 32'hFFFF_FF80, 1'b0);
    do_op(1'b0, 3'b100, 32'h1000_0003, 32'h0, 0, 32'h8000_0000,
          32'h1000_0000, 4'b1000, 32'h0, 32'h0000_0080, 1'b0);
    // sh upper half
    do_op(1'b1, 3'b001, 32'h1000_0002, 32'h0000_ABCD, 2, 32'h1234_5678,
          32'h1000_0000, 4'b1100, 32'hABCD_0000, 32'h0, 1'b0);
    // sb: bits above the byte must not reach other lanes
    do_op(1'b1, 3'b000, 32'h1000_0001, 32'hFFFF_FF5A, 0, 32'h0,
          32'h1000_0000, 4'b0010, 32'h0000_5A00, 32'h0, 1'b0);
    // lh / lhu upper half, negative
    do_op(1'b0, 3'b001, 32'h1000_0002, 32'h0, 1, 32'h9234_0000,
          32'h1000_0000, 4'b1100, 32'h0, 32'hFFFF_9234, 1'b0);
    do_op(1'b0, 3'b101, 32'h1000_0002, 32'h0, 0, 32'h9234_0000,
          32'h1000_0000, 4'b1100, 32'h0, 32'h0000_9234, 1'b0);
    // illegal funct3 for XLEN=32
    do_op(1'b0, 3'b011, 32'h1000_0000, 32'h0, 0, 32'h0, 32'h0, 4'b0, 32'h0, 32'h0, 1'b1);
    do_op(1'b0, 3'b111, 32'h1000_0000, 32'h0, 0, 32'h0, 32'h0, 4'b0, 32'h0, 32'h0, 1'b1);
    do_op(1'b1, 3'b100, 32'h1000_0000, 32'h5, 0, 32'h0, 32'h0, 4'b0, 32'h0, 32'h0, 1'b1);

`ifdef LSU_MISALIGN_SPLIT_EN
    // lw crossing a word boundary: two accesses, bytes merged
    req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h1000_0006;
    @(negedge clk);
    req_valid = 1'b0;
    chk("split lo addr", 64'(mem_addr), 64'(32'h1000_0004));
    chk("split lo en", 64'(mem_byte_en), 64'(4'b1100));
    mem_resp = 1'b1; mem_rdata = 32'h1122_3344;
    @(negedge clk);
    chk("split hi addr", 64'(mem_addr), 64'(32'h1000_0008));
    chk("split hi en", 64'(mem_byte_en), 64'(4'b0011));
    chk("split no early resp", 64'(resp_valid), 64'(0));
    mem_rdata = 32'h5566_7788;
    @(negedge clk);
    mem_resp = 1'b0; mem_rdata = '0;
    chk("split resp_valid", 64'(resp_valid), 64'(1));
    chk("split resp_rdata", 64'(resp_rdata), 64'(32'h7788_1122));
    chk("split resp_err", 64'(resp_err), 64'(0));
    @(negedge clk);
`else
    // misaligned lw is an error with no memory access
    do_op(1'b0, 3'b010, 32'h1000_0006, 32'h0, 0, 32'h0, 32'h0, 4'b0, 32'h0, 32'h0, 1'b1);
    do_op(1'b0, 3'b001, 32'h1000_0003, 32'h0, 0, 32'h0, 32'h0, 4'b0, 32'h0, 32'h0, 1'b1);
`endif

    // reset while waiting in REQ_LO
    req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h1000_0010;
    @(negedge clk);
    req_valid = 1'b0;
    chk("pre-rst mem_read", 64'(mem_read), 64'(1));
    #2 rst = 1'b0;
    #1;
    chk("rst drops mem_read", 64'(mem_read), 64'(0));
    chk("rst req_ready", 64'(req_ready), 64'(0));
    @(negedge clk);
    rst = 1'b1;
    mem_resp = 1'b1; mem_rdata = 32'h0BAD_0BAD;
    @(negedge clk);
    mem_resp = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("no resp after rst", 64'({resp_valid, mem_read}), 64'(0));
      @(negedge clk);
    end
    do_op(1'b0, 3'b010, 32'h1000_0020, 32'h0, 1, 32'h0102_0304,
          32'h1000_0020, 4'b1111, 32'h0, 32'h0102_0304, 1'b0);

    // request held off while busy, accepted in DONE
    req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h1000_0008;
    @(negedge clk);
    req_funct3 = 3'b100; req_addr = 32'h1000_0001;
    chk("busy req_ready", 64'(req_ready), 64'(0));
    chk("busy mem_addr", 64'(mem_addr), 64'(32'h1000_0008));
    mem_resp = 1'b1; mem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    mem_resp = 1'b0;
    chk("b2b resp_valid", 64'(resp_valid), 64'(1));
    chk("b2b resp_rdata", 64'(resp_rdata), 64'(32'hCAFE_F00D));
    chk("b2b ready in DONE", 64'(req_ready), 64'(1));
    @(negedge clk);
    req_valid = 1'b0;
    chk("b2b second mem_read", 64'(mem_read), 64'(1));
    chk("b2b second addr", 64'(mem_addr), 64'(32'h1000_0000));
    chk("b2b second en", 64'(mem_byte_en), 64'(4'b0010));
    chk("b2b no dup resp", 64'(resp_valid), 64'(0));
    mem_resp = 1'b1; mem_rdata = 32'h0000_F100;
    @(negedge clk);
    mem_resp = 1'b0;
    chk("b2b lbu resp", 64'({resp_valid, resp_rdata}), 64'({1'b1, 32'h0000_00F1}));
    @(negedge clk);
    chk("b2b single resp", 64'(resp_valid), 64'(0));
    chk("b2b idle", 64'(mem_read), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
